// File: rtl/fpu_sched_pkg.sv
// Shared types and defaults for the two-requester FPU core scheduler.
package fpu_sched_pkg;

  localparam int unsigned OPCODE_W    = 5;
  localparam int unsigned TIMEOUT_DEF = 127;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } sched_state_e;

  typedef struct packed {
    logic nv;
    logic dz;
    logic ovf;
    logic unf;
    logic nx;
  } fpu_status_t;

  localparam fpu_status_t STATUS_TIMEOUT = '{nv: 1'b1, default: 1'b0};

endpackage

// File: rtl/fpu_sched_rr2.sv
// Two-way round-robin arbiter: one-hot grant from two valids, priority
// pointer loaded from upd_prio_i when upd_i is strobed.
module fpu_sched_rr2 (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] valid_i,
  input  logic       upd_i,
  input  logic       upd_prio_i,
  output logic [1:0] grant_o
);

  logic prio_q, prio_d;

  always_comb begin
    grant_o = 2'b00;
    unique case (valid_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      2'b11:   grant_o = prio_q ? 2'b10 : 2'b01;
      default: grant_o = 2'b00;
    endcase
  end

  always_comb begin
    prio_d = prio_q;
    if (upd_i) begin
      prio_d = upd_prio_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prio_q <= 1'b0;
    end else begin
      prio_q <= prio_d;
    end
  end

endmodule

// File: rtl/fpu_core_sched.sv
// Round-robin scheduler for an iterative FPU core (level enable, ready edge).
// Define FPU_SCHED_TIMEOUT_EN to add the BUSY watchdog.
module fpu_core_sched
  import fpu_sched_pkg::*;
#(
  parameter int unsigned WIDTH   = 64,
  parameter int unsigned TAG_W   = 8,
  parameter int unsigned OP_W    = OPCODE_W,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   flush_i,
  input  logic [1:0]             req_valid_i,
  output logic [1:0]             req_ready_o,
  input  logic [2*OP_W-1:0]      req_op_i,
  input  logic [2*3*WIDTH-1:0]   req_opnd_i,
  input  logic [2*TAG_W-1:0]     req_tag_i,
  output logic [1:0]             rsp_valid_o,
  input  logic [1:0]             rsp_ready_i,
  output logic [WIDTH-1:0]       rsp_result_o,
  output logic [4:0]             rsp_status_o,
  output logic [TAG_W-1:0]       rsp_tag_o,
  output logic                   rsp_timeout_o,
  output logic                   core_enable_o,
  output logic [OP_W-1:0]        core_op_o,
  output logic [WIDTH-1:0]       core_opa_o,
  output logic [WIDTH-1:0]       core_opb_o,
  output logic [WIDTH-1:0]       core_opc_o,
  input  logic                   core_ready_i,
  input  logic [WIDTH-1:0]       core_out_i,
  input  logic [4:0]             core_flags_i
);

  sched_state_e     state_q, state_d;
  logic             owner_q, owner_d;
  logic [OP_W-1:0]  op_q, op_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] opc_q, opc_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  fpu_status_t      status_q, status_d;
  logic             ready_q, ready_d;

  logic [1:0] arb_valid;
  logic [1:0] grant;
  logic       sel;
  logic       prio_upd;
  logic       prio_nxt;
  logic       core_edge;

`ifdef FPU_SCHED_TIMEOUT_EN
  localparam int unsigned CNT_W = ($clog2(TIMEOUT + 1) > 7) ? $clog2(TIMEOUT + 1) : 7;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;
`endif

  // Arbitration only runs in IDLE and is masked by flush/reset, so
  // req_ready_o is simply the arbiter grant.
  assign arb_valid = (state_q == ST_IDLE && !flush_i && !rst_i) ? req_valid_i : 2'b00;

  fpu_sched_rr2 u_arb (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .valid_i    (arb_valid),
    .upd_i      (prio_upd),
    .upd_prio_i (prio_nxt),
    .grant_o    (grant)
  );

  assign sel       = grant[1];
  assign core_edge = core_ready_i & ~ready_q;

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    op_d     = op_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    opc_d    = opc_q;
    tag_d    = tag_q;
    result_d = result_q;
    status_d = status_q;
    ready_d  = core_ready_i;
    prio_upd = 1'b0;
    prio_nxt = ~owner_q;
`ifdef FPU_SCHED_TIMEOUT_EN
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (|grant) begin
          state_d = ST_BUSY;
          owner_d = sel;
          op_d    = sel ? req_op_i[OP_W +: OP_W]        : req_op_i[0 +: OP_W];
          opa_d   = sel ? req_opnd_i[3*WIDTH +: WIDTH]  : req_opnd_i[0 +: WIDTH];
          opb_d   = sel ? req_opnd_i[4*WIDTH +: WIDTH]  : req_opnd_i[WIDTH +: WIDTH];
          opc_d   = sel ? req_opnd_i[5*WIDTH +: WIDTH]  : req_opnd_i[2*WIDTH +: WIDTH];
          tag_d   = sel ? req_tag_i[TAG_W +: TAG_W]     : req_tag_i[0 +: TAG_W];
`ifdef FPU_SCHED_TIMEOUT_EN
          cnt_d     = '0;
          timeout_d = 1'b0;
`endif
        end
      end
      ST_BUSY: begin
        if (core_edge) begin
          state_d  = ST_RESP;
          result_d = core_out_i;
          status_d = fpu_status_t'(core_flags_i);
`ifdef FPU_SCHED_TIMEOUT_EN
        end else if (cnt_q == CNT_W'(TIMEOUT)) begin
          state_d   = ST_RESP;
          result_d  = '0;
          status_d  = STATUS_TIMEOUT;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
`endif
        end
      end
      ST_RESP: begin
        if (rsp_ready_i[owner_q]) begin
          state_d  = ST_IDLE;
          prio_upd = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (flush_i) begin
      state_d  = ST_IDLE;
      prio_upd = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      owner_q  <= 1'b0;
      op_q     <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      opc_q    <= '0;
      tag_q    <= '0;
      result_q <= '0;
      status_q <= '0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      op_q     <= op_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      opc_q    <= opc_d;
      tag_q    <= tag_d;
      result_q <= result_d;
      status_q <= status_d;
      ready_q  <= ready_d;
    end
  end

`ifdef FPU_SCHED_TIMEOUT_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign rsp_timeout_o = timeout_q;
`else
  assign rsp_timeout_o = 1'b0;
`endif

  assign req_ready_o   = grant;
  assign rsp_valid_o   = (state_q == ST_RESP) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_result_o  = result_q;
  assign rsp_status_o  = status_q;
  assign rsp_tag_o     = tag_q;
  assign core_enable_o = (state_q == ST_BUSY);
  assign core_op_o     = op_q;
  assign core_opa_o    = opa_q;
  assign core_opb_o    = opb_q;
  assign core_opc_o    = opc_q;

endmodule

// File: tb/tb_fpu_core_sched.sv
// Self-checking bench for fpu_core_sched: vector table plus hand sequences,
// scoreboard filled on accept and drained on response handshake.
module tb_fpu_core_sched;

  localparam int unsigned WIDTH = 64;
  localparam int unsigned TAG_W = 8;
  localparam int unsigned OP_W  = 5;
  localparam int unsigned TMO   = 20;

  logic                 clk = 1'b0;
  logic                 rst_i;
  logic                 flush_i;
  logic [1:0]           req_valid_i;
  logic [1:0]           req_ready_o;
  logic [2*OP_W-1:0]    req_op_i;
  logic [2*3*WIDTH-1:0] req_opnd_i;
  logic [2*TAG_W-1:0]   req_tag_i;
  logic [1:0]           rsp_valid_o;
  logic [1:0]           rsp_ready_i;
  logic [WIDTH-1:0]     rsp_result_o;
  logic [4:0]           rsp_status_o;
  logic [TAG_W-1:0]     rsp_tag_o;
  logic                 rsp_timeout_o;
  logic                 core_enable_o;
  logic [OP_W-1:0]      core_op_o;
  logic [WIDTH-1:0]     core_opa_o, core_opb_o, core_opc_o;
  logic                 core_ready_i;
  logic [WIDTH-1:0]     core_out_i;
  logic [4:0]           core_flags_i;

  always #5 clk = ~clk;

  fpu_core_sched #(
    .WIDTH   (WIDTH),
    .TAG_W   (TAG_W),
    .OP_W    (OP_W),
    .TIMEOUT (TMO)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .flush_i       (flush_i),
    .req_valid_i   (req_valid_i),
    .req_ready_o   (req_ready_o),
    .req_op_i      (req_op_i),
    .req_opnd_i    (req_opnd_i),
    .req_tag_i     (req_tag_i),
    .rsp_valid_o   (rsp_valid_o),
    .rsp_ready_i   (rsp_ready_i),
    .rsp_result_o  (rsp_result_o),
    .rsp_status_o  (rsp_status_o),
    .rsp_tag_o     (rsp_tag_o),
    .rsp_timeout_o (rsp_timeout_o),
    .core_enable_o (core_enable_o),
    .core_op_o     (core_op_o),
    .core_opa_o    (core_opa_o),
    .core_opb_o    (core_opb_o),
    .core_opc_o    (core_opc_o),
    .core_ready_i  (core_ready_i),
    .core_out_i    (core_out_i),
    .core_flags_i  (core_flags_i)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0]       owner;
    logic [TAG_W-1:0] tag;
    logic [WIDTH-1:0] res;
    logic [4:0]       st;
    logic             tmo;
  } exp_t;

  exp_t sb[$];
  logic exp_tmo = 1'b0;

  function automatic logic [WIDTH-1:0] f_res(logic [OP_W-1:0] op, logic [WIDTH-1:0] a,
                                             logic [WIDTH-1:0] b, logic [WIDTH-1:0] c);
    return (a ^ {b[31:0], b[63:32]}) + c + WIDTH'(op);
  endfunction

  function automatic logic [4:0] f_flags(logic [OP_W-1:0] op);
    return op ^ 5'b10101;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Behavioural core: ready rises core_lat cycles into enable, drops with enable.
  int unsigned core_lat = 3;
  int unsigned core_cnt = 0;
  always @(posedge clk) begin
    if (!core_enable_o) begin
      core_cnt     <= 0;
      core_ready_i <= 1'b0;
    end else begin
      core_cnt <= core_cnt + 1;
      if (core_cnt + 1 >= core_lat) core_ready_i <= 1'b1;
    end
  end
  assign core_out_i   = f_res(core_op_o, core_opa_o, core_opb_o, core_opc_o);
  assign core_flags_i = f_flags(core_op_o);

  // Scoreboard monitor: accepts and response handshakes resolve at the next posedge.
  always @(negedge clk) begin : mon
    exp_t e;
    int   g;
    if (!rst_i) begin
      if ((req_valid_i & req_ready_o) != 2'b00) begin
        chk("req_ready_onehot", 64'($countones(req_ready_o)), 64'd1);
        g       = req_ready_o[1] ? 1 : 0;
        e.owner = (g == 1) ? 2'b10 : 2'b01;
        e.tag   = req_tag_i[g*TAG_W +: TAG_W];
        if (exp_tmo) begin
          e.res = '0;
          e.st  = 5'b10000;
          e.tmo = 1'b1;
        end else begin
          e.res = f_res(req_op_i[g*OP_W +: OP_W], req_opnd_i[g*3*WIDTH +: WIDTH],
                        req_opnd_i[g*3*WIDTH + WIDTH +: WIDTH],
                        req_opnd_i[g*3*WIDTH + 2*WIDTH +: WIDTH]);
          e.st  = f_flags(req_op_i[g*OP_W +: OP_W]);
          e.tmo = 1'b0;
        end
        sb.push_back(e);
      end
      if ((rsp_valid_o & rsp_ready_i) != 2'b00) begin
        if (sb.size() == 0) begin
          chk("rsp_unexpected", 64'(rsp_valid_o), 64'd0);
        end else begin
          e = sb.pop_front();
          chk("rsp_owner", 64'(rsp_valid_o), 64'(e.owner));
          chk("rsp_tag", 64'(rsp_tag_o), 64'(e.tag));
          chk("rsp_result", rsp_result_o, e.res);
          chk("rsp_status", 64'(rsp_status_o), 64'(e.st));
          chk("rsp_timeout", 64'(rsp_timeout_o), 64'(e.tmo));
        end
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst_i = 1'b1;
    sb.delete();
    repeat (2) @(posedge clk);
    #1 rst_i = 1'b0;
  endtask

  task automatic set_req(int r, logic [OP_W-1:0] op, logic [WIDTH-1:0] a, logic [WIDTH-1:0] b,
                         logic [WIDTH-1:0] c, logic [TAG_W-1:0] tag);
    req_op_i[r*OP_W +: OP_W]          = op;
    req_opnd_i[r*3*WIDTH +: 3*WIDTH]  = {c, b, a};
    req_tag_i[r*TAG_W +: TAG_W]       = tag;
  endtask

  task automatic wait_grant(int r);
    bit ok = 1'b0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (req_ready_o[r]) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("grant_wait_expired", 64'd0, 64'd1);
  endtask

  // Returns at posedge+1 of the first BUSY cycle.
  task automatic issue(int r, logic [OP_W-1:0] op, logic [WIDTH-1:0] a, logic [WIDTH-1:0] b,
                       logic [WIDTH-1:0] c, logic [TAG_W-1:0] tag);
    @(posedge clk); #1;
    set_req(r, op, a, b, c, tag);
    req_valid_i[r] = 1'b1;
    wait_grant(r);
    @(posedge clk); #1;
    req_valid_i[r] = 1'b0;
  endtask

  task automatic drain();
    bit ok = 1'b0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (sb.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("drain_expired", 64'(sb.size()), 64'd0);
  endtask

  task automatic wait_rsp();
    bit ok = 1'b0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (rsp_valid_o != 2'b00) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("rsp_wait_expired", 64'd0, 64'd1);
  endtask

  // Both requesters valid continuously; grants must alternate from 'first'.
  task automatic alt(int first);
    int got = 0;
    int exp_g = first;
    int g;
    @(posedge clk); #1;
    core_lat    = 3;
    rsp_ready_i = 2'b11;
    set_req(0, 5'd3, 64'h0123_4567_89ab_cdef, 64'h1, 64'h2, 8'hA0);
    set_req(1, 5'd9, 64'hfeed_0000_beef_0001, 64'h3, 64'h4, 8'hB0);
    req_valid_i = 2'b11;
    for (int n = 0; n < 400 && got < 4; n++) begin
      @(negedge clk);
      if (req_ready_o != 2'b00) begin
        chk("alt_grant", 64'(req_ready_o), (exp_g == 1) ? 64'd2 : 64'd1);
        g = req_ready_o[1] ? 1 : 0;
        @(posedge clk); #1;
        req_tag_i[g*TAG_W +: TAG_W] = req_tag_i[g*TAG_W +: TAG_W] + 8'd1;
        got++;
        exp_g = 1 - exp_g;
      end
    end
    if (got < 4) chk("alt_count", 64'(got), 64'd4);
    req_valid_i = 2'b00;
    drain();
  endtask

  typedef struct {
    int               r;
    logic [OP_W-1:0]  op;
    logic [WIDTH-1:0] a, b, c;
    logic [TAG_W-1:0] tag;
    int unsigned      lat;
  } vec_t;

  vec_t vt[6];

  initial begin : watchdog
    #2ms;
    $display("FAIL global_time_limit: got expired expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    int viol;
    logic [WIDTH-1:0] exp_r;

    vt[0] = '{r: 0, op: 5'd0,  a: 64'h0,                  b: 64'h0,                  c: 64'h0,                  tag: 8'h01, lat: 1};
    vt[1] = '{r: 1, op: 5'd31, a: 64'hffff_ffff_ffff_ffff, b: 64'hffff_ffff_ffff_ffff, c: 64'hffff_ffff_ffff_ffff, tag: 8'hff, lat: 2};
    vt[2] = '{r: 0, op: 5'd7,  a: 64'h3ff0_0000_0000_0000, b: 64'h4000_0000_0000_0000, c: 64'h1,                  tag: 8'h00, lat: 5};
    vt[3] = '{r: 1, op: 5'd12, a: 64'hdead_beef_cafe_f00d, b: 64'h0000_0001_0000_0002, c: 64'h8000_0000_0000_0000, tag: 8'h5a, lat: 1};
    vt[4] = '{r: 1, op: 5'd1,  a: 64'h1,                  b: 64'h8000_0000_0000_0001, c: 64'h7fff_ffff_ffff_ffff, tag: 8'h80, lat: 7};
    vt[5] = '{r: 0, op: 5'd16, a: 64'h5555_aaaa_5555_aaaa, b: 64'haaaa_5555_aaaa_5555, c: 64'h10,                 tag: 8'h7e, lat: 3};

    rst_i       = 1'b1;
    flush_i     = 1'b0;
    req_valid_i = 2'b01;
    req_op_i    = '0;
    req_opnd_i  = '0;
    req_tag_i   = '0;
    rsp_ready_i = 2'b11;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_req_ready", 64'(req_ready_o), 64'd0);
    chk("reset_rsp_valid", 64'(rsp_valid_o), 64'd0);
    chk("reset_core_enable", 64'(core_enable_o), 64'd0);
    chk("reset_rsp_result", rsp_result_o, 64'd0);
    chk("reset_rsp_tag", 64'(rsp_tag_o), 64'd0);
    chk("reset_rsp_timeout", 64'(rsp_timeout_o), 64'd0);
    @(posedge clk); #1;
    req_valid_i = 2'b00;
    rst_i       = 1'b0;

    // Single request, edge-to-response latency, then prio must point at req 1.
    core_lat = 10;
    issue(0, 5'd6, 64'h4008_0000_0000_0000, 64'h4010_0000_0000_0000, 64'h0, 8'h11);
    n = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (core_ready_i) begin
        n = 1;
        break;
      end
    end
    chk("core_edge_seen", 64'(n), 64'd1);
    @(negedge clk);
    chk("edge_to_rsp", 64'(rsp_valid_o), 64'd1);
    drain();
    alt(1);

    // Vector table.
    for (int i = 0; i < 6; i++) begin
      core_lat = vt[i].lat;
      issue(vt[i].r, vt[i].op, vt[i].a, vt[i].b, vt[i].c, vt[i].tag);
      drain();
    end

    // Alternation from a cleared priority pointer.
    do_reset();
    alt(0);

    // Response backpressure: stable response, no accept, next accept at R+1.
    core_lat = 3;
    @(posedge clk); #1;
    rsp_ready_i = 2'b00;
    issue(0, 5'd5, 64'h1234, 64'h5678, 64'h9abc, 8'h55);
    exp_r = f_res(5'd5, 64'h1234, 64'h5678, 64'h9abc);
    set_req(1, 5'd2, 64'h77, 64'h88, 64'h99, 8'h66);
    req_valid_i[1] = 1'b1;
    wait_rsp();
    for (int k = 0; k < 5; k++) begin
      chk("bp_rsp_valid", 64'(rsp_valid_o), 64'd1);
      chk("bp_rsp_tag", 64'(rsp_tag_o), 64'h55);
      chk("bp_rsp_result", rsp_result_o, exp_r);
      chk("bp_no_accept", 64'(req_ready_o), 64'd0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    rsp_ready_i = 2'b11;
    @(posedge clk);
    @(negedge clk);
    chk("bp_accept_after_hs", 64'(req_ready_o), 64'd2);
    @(posedge clk); #1;
    req_valid_i[1] = 1'b0;
    drain();

    // Flush two cycles into BUSY, then a fresh request from req 1.
    core_lat = 10;
    issue(0, 5'd4, 64'hab, 64'hcd, 64'hef, 8'h33);
    @(posedge clk); #1;
    flush_i = 1'b1;
    sb.delete();
    set_req(1, 5'd8, 64'h1111, 64'h2222, 64'h3333, 8'h44);
    req_valid_i[1] = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("flush_core_enable", 64'(core_enable_o), 64'd0);
    chk("flush_req_ready", 64'(req_ready_o), 64'd0);
    chk("flush_rsp_valid", 64'(rsp_valid_o), 64'd0);
    @(posedge clk); #1;
    flush_i = 1'b0;
    wait_grant(1);
    @(posedge clk); #1;
    req_valid_i[1] = 1'b0;
    drain();

    // Watchdog behaviour with a core that never completes.
    do_reset();
    core_lat = 100000;
`ifdef FPU_SCHED_TIMEOUT_EN
    @(posedge clk); #1;
    exp_tmo = 1'b1;
    issue(0, 5'd10, 64'h1, 64'h2, 64'h3, 8'h77);
    n = -1;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (rsp_valid_o != 2'b00) begin
        n = k;
        break;
      end
    end
    chk("tmo_latency", 64'(n), 64'(TMO + 1));
    drain();
    exp_tmo = 1'b0;
`else
    issue(0, 5'd10, 64'h1, 64'h2, 64'h3, 8'h77);
    viol = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (rsp_valid_o != 2'b00 || !core_enable_o) viol++;
    end
    chk("no_wd_stays_busy", 64'(viol), 64'd0);
    @(posedge clk); #1;
    flush_i = 1'b1;
    sb.delete();
    @(posedge clk); #1;
    flush_i = 1'b0;
`endif

    // Reset while in RESP: outputs clear and prio returns to 0.
    core_lat = 2;
    issue(0, 5'd3, 64'h10, 64'h20, 64'h30, 8'h21);
    drain();
    @(posedge clk); #1;
    rsp_ready_i = 2'b00;
    issue(0, 5'd11, 64'hfff, 64'heee, 64'hddd, 8'h88);
    wait_rsp();
    @(posedge clk); #1;
    rst_i = 1'b1;
    sb.delete();
    @(posedge clk); #1;
    rst_i = 1'b0;
    @(negedge clk);
    chk("rst_resp_rsp_valid", 64'(rsp_valid_o), 64'd0);
    chk("rst_resp_core_enable", 64'(core_enable_o), 64'd0);
    chk("rst_resp_result", rsp_result_o, 64'd0);
    chk("rst_resp_status", 64'(rsp_status_o), 64'd0);
    chk("rst_resp_tag", 64'(rsp_tag_o), 64'd0);
    chk("rst_resp_core_op", 64'(core_op_o), 64'd0);
    chk("rst_resp_core_opa", core_opa_o, 64'd0);
    chk("rst_resp_req_ready", 64'(req_ready_o), 64'd0);
    alt(0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
